// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as an 8N1 frame LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    // Handshake: a byte moves when tx_valid and tx_ready are both high at a posedge;
    // tx_ready is high only in IDLE, and tx_valid outside IDLE is ignored, never queued.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_end  = (cnt == LAST_CNT);
    assign tx_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            txd       <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            shift_reg <= 8'h00;
            cnt       <= '0;
            bit_idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (tx_valid) begin
                        shift_reg <= tx_data;
                        cnt       <= '0;
                        bit_idx   <= 3'd0;
                        txd       <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        txd   <= shift_reg[0];
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // txd is registered, so drive the bit that becomes bit 0 after this shift
                            txd <= shift_reg[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison against a frame-level line model,
// plus directed handshake, back-to-back, reset and random traffic scenarios.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;
    localparam int BUDGET     = FRAME_CLKS + 20;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, tx_busy, tx_done;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // ---------------- counters / check task ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds the expected line level for every remaining cycle of the current frame.
    logic [0:0] exp_q[$];
    logic m_txd = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    int   m_acc_n = 0, m_acc_cyc = 0, m_prev_acc_cyc = 0;

    task automatic build_frame(input logic [7:0] d);
        logic [0:0] bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[b]) repeat (CPB) exp_q.push_back(bits[b]);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            exp_q.delete();
            m_txd = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_ready && tx_valid) begin
            build_frame(tx_data);
            m_txd = exp_q.pop_front();
            m_ready = 1'b0; m_busy = 1'b1; m_done = 1'b0;
            m_acc_n++;
            m_prev_acc_cyc = m_acc_cyc;
            m_acc_cyc = cyc;
        end else if (exp_q.size() > 0) begin
            m_txd = exp_q.pop_front();
            m_done = 1'b0;
        end else begin
            m_done = !m_ready;
            m_ready = 1'b1; m_busy = 1'b0; m_txd = 1'b1;
        end
    end

    // ---------------- per-cycle scoreboard ----------------
    int done_n = 0, last_done_cyc = 0;

    always @(negedge clk) begin
        check("txd",      32'(txd),      32'(m_txd));
        check("tx_ready", 32'(tx_ready), 32'(m_ready));
        check("tx_busy",  32'(tx_busy),  32'(m_busy));
        check("tx_done",  32'(tx_done),  32'(m_done));
        if (tx_done === 1'b1) begin
            done_n++;
            last_done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input int target);
        for (int i = 0; i < BUDGET && m_acc_n < target; i++) @(negedge clk);
        check("accept_seen", 32'(m_acc_n >= target), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n0;
        @(negedge clk);
        n0 = m_acc_n;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        wait_acc(n0 + 1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (m_ready && tx_ready === 1'b1) break;
        end
        check("idle_timeout", 32'(i < BUDGET), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int d0;

    initial begin
        // Reset hold with tx_valid asserted: nothing may start.
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
        repeat (3) @(negedge clk);
        check("rst_hold_ready", 32'(tx_ready), 32'd1);
        check("rst_hold_txd",   32'(txd),      32'd1);
        tx_valid = 1'b0; rst = 1'b1;
        idle_cycles(3);
        check("post_rst_busy", 32'(tx_busy), 32'd0);

        // Single byte 8'hA5.
        d0 = done_n;
        send_byte(8'hA5);
        wait_idle();
        check("a5_done_cnt", 32'(done_n - d0), 32'd1);
        check("a5_done_lat", 32'(last_done_cyc - m_acc_cyc), 32'(FRAME_CLKS));

        // Back-to-back with tx_valid held: 8'h00 then 8'hFF.
        d0 = done_n;
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        wait_acc(m_acc_n);
        tx_data = 8'hFF;
        wait_acc(m_acc_n + 1);
        tx_valid = 1'b0;
        check("b2b_gap", 32'(m_acc_cyc - m_prev_acc_cyc), 32'(FRAME_CLKS + 1));
        wait_idle();
        check("b2b_done_cnt", 32'(done_n - d0), 32'd2);

        // Data stability: tx_data changes during DATA must not reach the line.
        send_byte(8'h3C);
        idle_cycles(2 * CPB);
        tx_data = 8'hC3;
        wait_idle();

        // Mid-frame reset during data bit 3, then a clean 8'h55.
        d0 = done_n;
        send_byte(8'h96);
        idle_cycles(4 * CPB);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", 32'(txd), 32'd1);
        idle_cycles(FRAME_CLKS);
        check("midrst_no_done", 32'(done_n - d0), 32'd0);
        send_byte(8'h55);
        wait_idle();
        check("after_rst_done_cnt", 32'(done_n - d0), 32'd1);

        // Reset in the same cycle as a would-be acceptance: byte is dropped.
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h81;
        @(negedge clk);
        rst = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        check("rst_acc_busy", 32'(tx_busy), 32'd0);

        // Parity-relevant bytes (plain 8N1 when the option is off).
        send_byte(8'h07);
        wait_idle();
        check("p07_done_lat", 32'(last_done_cyc - m_acc_cyc), 32'(FRAME_CLKS));
        send_byte(8'h03);
        wait_idle();

        // Random traffic: sporadic valid, noisy tx_data, rare resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 7) == 0);
            tx_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) != 0);
        end
        tx_valid = 1'b0; rst = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the send-side counterpart of the team's uart_rx.
- Accepts one byte per valid/ready handshake and serialises it on txd as an 8N1 frame, LSB first: start bit 0, 8 data bits, stop bit 1.
- Contains its own bit-period counter, so it needs no external baud tick. Frame timing is aligned to byte acceptance.
- Sits between the host-side byte source and the serial line pin.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset; rst=0 at a posedge resets the block.
- tx_data  input  8  byte to transmit; sampled only at acceptance.
- tx_valid  input  1  byte source has a byte on tx_data.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- txd  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress (any state except IDLE).
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, txd=1, tx_ready=1, tx_busy=0, tx_done=0, shift register=0, bit counter=0, bit index=0.
- States: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature). Encoding is 3 bits.
- IDLE:
  - txd=1, tx_ready=1.
  - Acceptance occurs at a posedge where tx_valid=1 and tx_ready=1.
  - On acceptance: latch tx_data into the shift register, clear the counter and bit index, go to START.
  - tx_valid while not in IDLE is ignored and is never queued.
- START:
  - txd=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after acceptance (latency 1 clk).
  - When counter==CLKS_PER_BIT-1: clear the counter, go to DATA.
- DATA:
  - txd = shift register bit 0.
  - At each bit end (counter==CLKS_PER_BIT-1): shift right by one, increment the bit index, clear the counter.
  - After bit index 7 completes, go to STOP.
  - Total 8*CLKS_PER_BIT cycles.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - At the end: tx_done=1 for that one cycle, go to IDLE.
- Frame length is 10*CLKS_PER_BIT cycles, measured from the cycle after acceptance to the cycle tx_ready rises.
- Back-to-back: tx_valid held high with new data is accepted on the first IDLE posedge. This gives a minimum 1-clk idle gap (txd=1) between frames. Throughput is one byte per 10*CLKS_PER_BIT+1 clks.
- tx_data is don't-care after acceptance; changes during a frame must not affect txd.
- Counter arithmetic: CNT_W-bit unsigned, compared against CLKS_PER_BIT-1. Wrap-around cannot occur; the counter is cleared at every bit end.
- Reset mid-frame: the frame is aborted, txd=1 on the following cycle, no tx_done pulse, tx_ready=1.
- Reset asserted in the same cycle as acceptance: reset wins and the byte is dropped.
- Outputs txd, tx_done and tx_busy are registered (glitch-free line drive). tx_ready is decoded from the registered state.
- Illegal state encoding: return to IDLE with txd=1 on the next cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - txd = even parity = XOR of the 8 latched data bits.
  - Frame length is 11*CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame is 8N1, length 10*CLKS_PER_BIT.

Test Plan:
- Reset hold: rst=0 for 3 clks with tx_valid=1 -> txd=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no frame starts.
- Single byte, CLKS_PER_BIT=4, tx_data=8'hA5 -> txd sequence per 4-clk bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulses exactly once, 40 clks after acceptance.
- Back-to-back, CLKS_PER_BIT=4, tx_valid held with 8'h00 then 8'hFF -> second START begins 41 clks after the first acceptance. Data bits all 0 then all 1. Exactly two tx_done pulses.
- Data stability, CLKS_PER_BIT=4: accept 8'h3C, then change tx_data to 8'hC3 during DATA -> line carries 8'h3C LSB first (0,0,1,1,1,1,0,0).
- Mid-frame reset, CLKS_PER_BIT=4: rst=0 for 1 clk during DATA bit 3 -> txd=1 the next cycle, no tx_done pulse. A new 8'h55 is then sent intact.
- With UART_TX_PARITY_EN, CLKS_PER_BIT=4: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0. Frame is 44 clks from acceptance to tx_done.
